// File: rtl/signed_serial_subtractor.sv
// Serial signed subtractor: accepts NUM_OPS operands per frame over valid/ready
// and returns first - second - ... - last at full precision, wrapped, and overflow.
module signed_serial_subtractor #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_OPS = 4,
  parameter int unsigned FULL_W  = WIDTH + $clog2(NUM_OPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FULL_W-1:0] out_full,
  output logic [WIDTH-1:0]  out_diff,
  output logic              out_ovf
);

  localparam int unsigned CNT_W = $clog2(NUM_OPS);
  localparam int unsigned TOP_W = FULL_W - WIDTH + 1;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  count;
  logic [FULL_W-1:0] acc;
  logic [FULL_W-1:0] in_ext;
  logic [FULL_W-1:0] acc_nxt;
  logic [TOP_W-1:0]  top_bits;
  logic              ovf_nxt;
  logic              in_hs;
  logic              out_hs;
  logic              last_op;

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign last_op = (count == CNT_W'(NUM_OPS - 1));

  // Operand arithmetic at full precision; the first operand seeds the accumulator.
  assign in_ext   = FULL_W'($signed(in_data));
  assign acc_nxt  = (count == '0) ? in_ext : (acc - in_ext);
  assign top_bits = acc_nxt[FULL_W-1:WIDTH-1];
  assign ovf_nxt  = (|top_bits) && !(&top_bits);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (in_hs && last_op) state_nxt = OUTPUT;
      OUTPUT:  if (out_hs)           state_nxt = ACCUM;
      default:                       state_nxt = ACCUM;
    endcase
  end

  // Handshake outputs decode straight from the state flop
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      OUTPUT:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Accumulator, operand counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      out_full <= '0;
      out_diff <= '0;
      out_ovf  <= 1'b0;
    end else if (in_hs) begin
      acc <= acc_nxt;
      if (last_op) begin
        count    <= '0;
        out_full <= acc_nxt;
        out_diff <= acc_nxt[WIDTH-1:0];
        out_ovf  <= ovf_nxt;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_signed_serial_subtractor.sv
// Bench for signed_serial_subtractor (WIDTH=8, NUM_OPS=4): directed table,
// corner sequences and random frames against an integer reference model.
module tb_signed_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_full;
  logic [7:0] out_diff;
  logic       out_ovf;

  int total = 0;
  int bad   = 0;

  signed_serial_subtractor #(.WIDTH(8), .NUM_OPS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_full (out_full),
    .out_diff (out_diff),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] ops;    // first operand in the top byte
    logic [15:0] gaps;   // idle cycles before each operand, top nibble first
    logic [9:0]  full;
    logic [7:0]  diff;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand and hold it until it is accepted (all driving at negedge)
  task automatic push(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [31:0] ops, input logic [15:0] gaps);
    for (int i = 0; i < 4; i++) begin
      idle(int'(gaps[15-4*i -: 4]));
      push(ops[31-8*i -: 8]);
    end
  endtask

  // Wait (bounded) for a result, compare it, then consume it
  task automatic take(input string name, input logic [9:0] full, input logic [7:0] diff,
                      input logic ovf);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_full"},  32'(out_full),  32'(full));
    chk({name, "_diff"},  32'(out_diff),  32'(diff));
    chk({name, "_ovf"},   32'(out_ovf),   32'(ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_done"}, 32'(out_valid), 32'd0);
  endtask

  // Reference: plain integer first - rest, then range check
  function automatic int model(input logic [31:0] ops);
    int r;
    r = int'($signed(ops[31:24]));
    r = r - int'($signed(ops[23:16]));
    r = r - int'($signed(ops[15:8]));
    r = r - int'($signed(ops[7:0]));
    return r;
  endfunction

  initial begin
    vec_t        vecs [4];
    logic [9:0]  hold_full;
    logic [7:0]  hold_diff;
    logic        hold_ovf;
    logic [31:0] rops;
    logic [15:0] rgaps;
    int          r;
    int          dly;
    logic [9:0]  efull;

    vecs[0] = '{"basic",   32'h92BFD5E0, 16'h0000, 10'h01E, 8'h1E, 1'b0};
    vecs[1] = '{"gaps",    32'hD5BFE092, 16'h0102, 10'h0A4, 8'hA4, 1'b1};
    vecs[2] = '{"ext_pos", 32'h7F808080, 16'h0000, 10'h1FF, 8'hFF, 1'b1};
    vecs[3] = '{"ext_neg", 32'h807F7F7F, 16'h0000, 10'h203, 8'h03, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full",      32'(out_full),  32'd0);
    chk("rst_diff",      32'(out_diff),  32'd0);
    chk("rst_ovf",       32'(out_ovf),   32'd0);

    // Directed table; out_valid must already be high one edge after the last operand
    foreach (vecs[i]) begin
      run_frame(vecs[i].ops, vecs[i].gaps);
      chk({vecs[i].name, "_latency"}, 32'(out_valid), 32'd1);
      take(vecs[i].name, vecs[i].full, vecs[i].diff, vecs[i].ovf);
    end

    // Backpressure: result frozen, offered operand not consumed while stalled
    run_frame(32'h92BFD5E0, 16'h0000);
    hold_full = out_full; hold_diff = out_diff; hold_ovf = out_ovf;
    chk("bp_full0", 32'(hold_full), 32'h01E);
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_full",     32'(out_full),  32'(hold_full));
      chk("bp_diff",     32'(out_diff),  32'(hold_diff));
      chk("bp_ovf",      32'(out_ovf),   32'(hold_ovf));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_after_ready", 32'(in_ready),  32'd1);
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    push(8'h00); push(8'h00); push(8'h00);
    take("bp_next", 10'h001, 8'h01, 1'b0);

    // Reset mid-frame discards the partial frame
    push(8'h55); push(8'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_full",     32'(out_full), 32'd0);
    run_frame(32'h10010203, 16'h0000);
    take("mid_rst", 10'h00A, 8'h0A, 1'b0);

    // Reset during OUTPUT drops the pending result
    run_frame(32'h11223344, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("out_rst_valid", 32'(out_valid), 32'd0);
    chk("out_rst_ovf",   32'(out_ovf),   32'd0);

    // Random frames with random gaps and random result stalls
    for (int f = 0; f < 40; f++) begin
      rops  = $urandom;
      rgaps = 16'($urandom) & 16'h3333;
      r     = model(rops);
      efull = r[9:0];
      run_frame(rops, rgaps);
      dly = int'($urandom_range(0, 3));
      in_valid = 1'b1;
      for (int k = 0; k < dly; k++) begin
        in_data = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      take("rand", efull, efull[7:0], (r > 127) || (r < -128));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_serial_subtractor.md
# signed_serial_subtractor

Sequential counterpart to the team's combinational signed multi-operand adder. It accepts a frame of NUM_OPS two's-complement operands, one per cycle, over a valid/ready stream. It returns `first − second − … − last` as a full-precision result, a WIDTH-bit wrapped result and an overflow flag. It sits between an operand producer and a result consumer; both sides may apply backpressure.

## Interface
- WIDTH, default 8: operand and wrapped-result width, signed two's complement.
- NUM_OPS, default 4: operands per frame, at least 2.
- FULL_W, default WIDTH+$clog2(NUM_OPS): width of the full-precision result.
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset; synchronous, active-high.
- in_valid, input, 1: operand valid.
- in_ready, output, 1: operand accepted when in_valid && in_ready.
- in_data, input, WIDTH: signed operand.
- out_valid, output, 1: result valid.
- out_ready, input, 1: result consumed when out_valid && out_ready.
- out_full, output, FULL_W: signed exact result.
- out_diff, output, WIDTH: low WIDTH bits of out_full (wrapped).
- out_ovf, output, 1: out_full lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].

## Operation
- The FSM has two states, ACCUM and OUTPUT. Reset state is ACCUM with count=0 and acc=0.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - On handshake with count==0: acc ← sign-extended in_data.
  - On handshake with count>0: acc ← acc − sign-extended in_data.
  - count increments on each handshake.
  - On the handshake where count==NUM_OPS−1, the final value is registered, the state moves to OUTPUT and count returns to 0.
- OUTPUT:
  - in_ready=0 and out_valid=1.
  - out_full, out_diff and out_ovf stay stable until the out handshake.
  - On the out handshake, the state returns to ACCUM.
- All arithmetic is done at FULL_W bits. FULL_W is enough to hold any result exactly, so out_full never wraps.
- out_diff = out_full[WIDTH−1:0]. This matches the team's 8-bit adders, which truncate silently.
- out_ovf = 1 when out_full[FULL_W−1:WIDTH−1] is not all zeros and not all ones.
- in_data is ignored when in_valid=0. Cycles with in_valid low leave acc and count unchanged, so gaps inside a frame are allowed.
- Reset values: in_ready=1, out_valid=0, out_full=0, out_diff=0, out_ovf=0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: out_valid rises on the first edge after the last operand's handshake cycle.
- Throughput: at best NUM_OPS+1 cycles per frame (NUM_OPS accept cycles plus at least one OUTPUT cycle).
- in_ready is low for the whole OUTPUT state. An in_valid held high during OUTPUT is not accepted. The next frame's first operand is accepted in the cycle after the out handshake, at the earliest.
- out_ready held low: the block stalls indefinitely, with outputs frozen and in_ready=0.
- Reset asserted mid-frame or during OUTPUT: the partial frame or pending result is discarded. The next cycle shows the reset values, and the next accepted operand is treated as the first of a new frame.
- Reset has priority over any simultaneous handshake.

## Test plan
All scenarios use WIDTH=8 and NUM_OPS=4.
- Reset: assert rst 2 cycles, then release → in_ready=1, out_valid=0, out_full=0, out_diff=0, out_ovf=0.
- Basic frame, in_valid held high: 0x92, 0xBF, 0xD5, 0xE0 → −110+65+43+32. Required: out_full=10'h01E, out_diff=8'h1E, out_ovf=0, with out_valid exactly 1 cycle after the 4th operand.
- Overflow with gaps: 0xD5, idle, 0xBF, 0xE0, idle, idle, 0x92 → out_full=10'h0A4 (164), out_diff=8'hA4, out_ovf=1.
- Extremes:
  - 0x7F, 0x80, 0x80, 0x80 → out_full=10'h1FF (511), out_diff=8'hFF, out_ovf=1.
  - 0x80, 0x7F, 0x7F, 0x7F → out_full=10'h203 (−509), out_diff=8'h03, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with data 0x01. Required: outputs stable, in_ready=0, no operand consumed. Then raise out_ready → the next frame starts with 0x01 accepted one cycle after the out handshake.
- Reset mid-frame: accept 2 operands, pulse rst, then send 0x10, 0x01, 0x02, 0x03 → out_full=10'h00A, out_ovf=0. No contribution from the pre-reset operands.
